// File: rtl/ascon_hash_xof_core.sv
// Ascon-Hash / Ascon-XOF engine (Ascon v1.2): 64-bit rate absorb/squeeze around an
// iterative p12 permutation that evaluates UNROLL rounds per clock.
module ascon_hash_xof_core #(
    parameter int unsigned UNROLL    = 1,
    parameter int unsigned MAX_OUT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 mode_xof,
    input  logic [MAX_OUT_W-1:0] out_words,
    input  logic                 msg_valid,
    output logic                 msg_ready,
    input  logic [63:0]          msg_data,
    input  logic                 msg_last,
    input  logic [3:0]           msg_bytes,
    output logic                 dig_valid,
    input  logic                 dig_ready,
    output logic [63:0]          dig_data,
    output logic                 dig_last,
    output logic                 busy,
    output logic                 done
);
    localparam logic [63:0] IvHash = 64'h00400c0000000100;
    localparam logic [63:0] IvXof  = 64'h00400c0000000000;
    localparam logic [63:0] PadFull = 64'h8000000000000000;
    localparam logic [3:0]  Step   = 4'(UNROLL);

    typedef enum logic [2:0] {
        StIdle, StInit, StAbsorb, StPermA, StPermP, StPermF, StSqueeze, StPermS
    } state_t;

    state_t               state;
    logic [4:0][63:0]     s;
    logic [3:0]           rnd;
    logic [MAX_OUT_W-1:0] cnt;
    logic [4:0][63:0]     perm_out;
    logic [63:0]          blk;
    logic                 perm_end;

    function automatic logic [63:0] ror(input logic [63:0] v, input int unsigned n);
        return (v >> n) | (v << (64 - n));
    endfunction

    function automatic logic [4:0][63:0] round_f(input logic [4:0][63:0] si, input logic [3:0] i);
        logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
        x0 = si[0];
        x1 = si[1];
        x2 = si[2] ^ {56'h0, 4'hf - i, i};
        x3 = si[3];
        x4 = si[4];
        x0 = x0 ^ x4;
        x4 = x4 ^ x3;
        x2 = x2 ^ x1;
        t0 = ~x0 & x1;
        t1 = ~x1 & x2;
        t2 = ~x2 & x3;
        t3 = ~x3 & x4;
        t4 = ~x4 & x0;
        x0 = x0 ^ t1;
        x1 = x1 ^ t2;
        x2 = x2 ^ t3;
        x3 = x3 ^ t4;
        x4 = x4 ^ t0;
        x1 = x1 ^ x0;
        x0 = x0 ^ x4;
        x3 = x3 ^ x2;
        x2 = ~x2;
        x0 = x0 ^ ror(x0, 19) ^ ror(x0, 28);
        x1 = x1 ^ ror(x1, 61) ^ ror(x1, 39);
        x2 = x2 ^ ror(x2, 1) ^ ror(x2, 6);
        x3 = x3 ^ ror(x3, 10) ^ ror(x3, 17);
        x4 = x4 ^ ror(x4, 7) ^ ror(x4, 41);
        return {x4, x3, x2, x1, x0};
    endfunction

    always_comb begin
        perm_out = s;
        for (int j = 0; j < int'(UNROLL); j++) begin
            perm_out = round_f(perm_out, rnd + 4'(j));
        end
    end

    assign perm_end = (rnd + Step) == 4'd12;

    // Final partial block: keep the valid leading bytes, place 0x80 right after them.
    always_comb begin
        blk = msg_data;
        if (msg_last && msg_bytes < 4'd8) begin
            for (int b = 0; b < 8; b++) begin
                if (b == int'(msg_bytes)) begin
                    blk[63-8*b -: 8] = 8'h80;
                end else if (b > int'(msg_bytes)) begin
                    blk[63-8*b -: 8] = 8'h00;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= StIdle;
            s         <= '0;
            rnd       <= '0;
            cnt       <= '0;
            msg_ready <= 1'b0;
            dig_valid <= 1'b0;
            dig_data  <= '0;
            dig_last  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (start) begin
                        s     <= {256'h0, (mode_xof ? IvXof : IvHash)};
                        cnt   <= !mode_xof ? MAX_OUT_W'(4) :
                                 (out_words == '0) ? MAX_OUT_W'(1) : out_words;
                        rnd   <= '0;
                        busy  <= 1'b1;
                        state <= StInit;
                    end
                end
                StInit, StPermA, StPermP, StPermF, StPermS: begin
                    s <= perm_out;
                    if (perm_end) begin
                        rnd <= '0;
                        case (state)
                            StInit, StPermA: begin
                                msg_ready <= 1'b1;
                                state     <= StAbsorb;
                            end
                            StPermP: begin
                                s[0]  <= perm_out[0] ^ PadFull;
                                state <= StPermF;
                            end
                            default: begin
                                dig_valid <= 1'b1;
                                dig_data  <= perm_out[0];
                                dig_last  <= (cnt == MAX_OUT_W'(1));
                                state     <= StSqueeze;
                            end
                        endcase
                    end else begin
                        rnd <= rnd + Step;
                    end
                end
                StAbsorb: begin
                    if (msg_valid) begin
                        s[0]      <= s[0] ^ blk;
                        msg_ready <= 1'b0;
                        if (!msg_last) begin
                            state <= StPermA;
                        end else if (msg_bytes >= 4'd8) begin
                            state <= StPermP;
                        end else begin
                            state <= StPermF;
                        end
                    end
                end
                StSqueeze: begin
                    if (dig_ready) begin
                        dig_valid <= 1'b0;
                        dig_last  <= 1'b0;
                        cnt       <= cnt - MAX_OUT_W'(1);
                        if (cnt == MAX_OUT_W'(1)) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= StIdle;
                        end else begin
                            state <= StPermS;
                        end
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end
endmodule
